// File: rtl/cla_seq_ctrl.sv
// Sequences one shared 8-bit CLA slice over NUM_BYTES cycles for wide add/sub.
// Two requesters share the slice via a round-robin arbiter; the carry ripples through a register.
module cla_seq_ctrl #(
  parameter int NUM_BYTES = 4,
  localparam int W = 8 * NUM_BYTES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_sub,
  input  logic [1:0]     req_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic           rsp_ovf,
  output logic [7:0]     add_a,
  output logic [7:0]     add_b,
  output logic           add_cin,
  input  logic [7:0]     add_sum,
  input  logic           add_cout
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry_q, ovf_q, id_q, last_q;
  logic [IDX_W-1:0]   idx_q;

  logic               gnt;
  logic               accept;
  logic               run;
  logic               last_byte;
  logic [W-1:0]       sel_a, sel_b;
  logic               sel_sub, sel_cin;

  // last_q holds the previous grant, so on a tie the other requester wins
  always_comb begin
    gnt = req_valid[1];
    if (req_valid == 2'b11) gnt = ~last_q;
  end

  assign sel_a   = gnt ? req_a[2*W-1:W] : req_a[W-1:0];
  assign sel_b   = gnt ? req_b[2*W-1:W] : req_b[W-1:0];
  assign sel_sub = gnt ? req_sub[1] : req_sub[0];
  assign sel_cin = gnt ? req_cin[1] : req_cin[0];

  assign accept    = (state_q == S_IDLE) && (|req_valid) && !rst;
  assign run       = (state_q == S_RUN) && !rst;
  assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (last_byte) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign add_a   = run ? a_q[8*idx_q +: 8] : 8'd0;
  assign add_b   = run ? b_q[8*idx_q +: 8] : 8'd0;
  assign add_cin = run ? carry_q : 1'b0;

  assign rsp_valid = (state_q == S_DONE) && !rst;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_id    = id_q;

  // Operand latches carry no reset: they are only read in RUN after an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= sel_a;
      b_q <= sel_sub ? ~sel_b : sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= '0;
        id_q    <= gnt;
        last_q  <= gnt;
        carry_q <= sel_sub | sel_cin;
      end else if (state_q == S_RUN) begin
        sum_q[8*idx_q +: 8] <= add_sum;
        carry_q             <= add_cout;
        if (last_byte) begin
          idx_q <= '0;
          ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Bench for cla_seq_ctrl: directed and randomized operations against a plain-arithmetic model.
module tb_cla_seq_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, req_sub, req_cin;
  logic [2*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0]   rsp_sum;
  logic [7:0]     add_a, add_b, add_sum;
  logic           add_cin, add_cout;

  cla_seq_ctrl #(.NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Combinational 8-bit adder slice the controller drives
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int last_g = 1;

  logic [W-1:0] ta [2];
  logic [W-1:0] tb_b [2];
  logic         ts [2];
  logic         tc [2];

  int           o_g, o_lat;
  logic [1:0]   o_rdy;
  logic [W-1:0] o_aw, o_bw, o_sum;
  logic         o_cin0, o_cout, o_ovf, o_id, o_vafter;
  bit           o_to, o_run_rdy_bad, o_unstable, o_done_rdy_bad;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin,
                                 output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      s  = full[W-1:0];
      co = full[W];
      ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 5)
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin);
    ta[r] = a; tb_b[r] = b; ts[r] = sub; tc[r] = cin;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_sub[r] = sub;
    req_cin[r] = cin;
    req_valid[r] = 1'b1;
  endtask

  // Runs one transaction from the sample point and records what was observed
  task automatic drive_op(input int hold);
    int k;
    logic [W-1:0] s0;
    logic c0, v0, i0;
    o_to = 0; o_run_rdy_bad = 0; o_unstable = 0; o_done_rdy_bad = 0;
    o_lat = -1; o_aw = '0; o_bw = '0; o_cin0 = 1'b0;
    #1;
    k = 0;
    while (req_ready == 2'b00) begin
      if (k > 20) begin o_to = 1; return; end
      @(negedge clk); #1;
      k++;
    end
    o_rdy = req_ready;
    o_g = req_ready[1] ? 1 : 0;
    @(posedge clk); #1;
    req_valid[o_g] = 1'b0;
    rsp_ready = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (req_ready !== 2'b00) o_run_rdy_bad = 1;
      if (rsp_valid === 1'b1) begin o_lat = k; break; end
      if (k <= NB) begin
        o_aw[8*(k-1) +: 8] = add_a;
        o_bw[8*(k-1) +: 8] = add_b;
        if (k == 1) o_cin0 = add_cin;
      end
    end
    if (o_lat < 0) begin o_to = 1; return; end
    s0 = rsp_sum; c0 = rsp_cout; v0 = rsp_ovf; i0 = rsp_id;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_sum !== s0 || rsp_cout !== c0 ||
          rsp_ovf !== v0 || rsp_id !== i0) o_unstable = 1;
      if (req_ready !== 2'b00) o_done_rdy_bad = 1;
    end
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 2'b00) o_done_rdy_bad = 1;
    o_sum = rsp_sum; o_cout = rsp_cout; o_ovf = rsp_ovf; o_id = rsp_id;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk); #1;
    o_vafter = rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    total++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf} !== 4'b0000) begin
      bad++; $display("FAIL reset_rsp_ctl got=%b exp=0000", {rsp_valid, rsp_id, rsp_cout, rsp_ovf});
    end
    total++;
    if (rsp_sum !== '0) begin bad++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
    total++;
    if ({add_a, add_b, add_cin} !== 17'd0) begin
      bad++; $display("FAIL reset_add got=%h exp=0", {add_a, add_b, add_cin});
    end
    req_valid = 2'b00;
    rst = 1'b0;
    last_g = 1;
  endtask

  task automatic test_alternate();
    int exp_g;
    logic [W-1:0] es; logic ec, eo;
    set_req(0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    set_req(1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) begin
      exp_g = 1 - last_g;
      total++;
      if (exp_g != i % 2) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", exp_g, i % 2); end
      ref_op(ta[exp_g], tb_b[exp_g], ts[exp_g], tc[exp_g], es, ec, eo);
      drive_op(0);
      total++;
      if (o_to) begin bad++; $display("FAIL alt_timeout got=1 exp=0"); return; end
      total++;
      if (o_rdy !== 2'(1 << exp_g)) begin bad++; $display("FAIL alt_grant got=%b exp=%0d", o_rdy, exp_g); end
      total++;
      if ({o_sum, o_cout, o_ovf, o_id} !== {es, ec, eo, 1'(exp_g)}) begin
        bad++; $display("FAIL alt_result got=%h/%b%b%b exp=%h/%b%b%0d", o_sum, o_cout, o_ovf, o_id, es, ec, eo, exp_g);
      end
      last_g = o_g;
      set_req(o_g, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    req_valid = 2'b00;
  endtask

  task automatic test_directed();
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive_op(0);
    total++;
    if (o_to || o_lat != NB + 1) begin bad++; $display("FAIL lat got=%0d exp=%0d", o_lat, NB + 1); end
    total++;
    if ({o_sum, o_cout, o_ovf, o_id} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_wrap got=%h/%b%b%b exp=00000000/100", o_sum, o_cout, o_ovf, o_id);
    end
    last_g = 0;

    set_req(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    drive_op(1);
    total++;
    if (o_bw !== 32'hFFFF_FFF8 || o_cin0 !== 1'b1) begin
      bad++; $display("FAIL sub_addb got=%h/%b exp=fffffff8/1", o_bw, o_cin0);
    end
    total++;
    if ({o_sum, o_cout, o_ovf, o_id} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sub_neg got=%h/%b%b%b exp=fffffffe/001", o_sum, o_cout, o_ovf, o_id);
    end
    last_g = 1;

    set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive_op(0);
    total++;
    if ({o_sum, o_cout, o_ovf, o_id} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_ovf got=%h/%b%b%b exp=80000000/010", o_sum, o_cout, o_ovf, o_id);
    end
    set_req(0, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    drive_op(0);
    total++;
    if ({o_sum, o_cout, o_ovf, o_id} !== {32'h1234_5679, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_cin got=%h/%b%b%b exp=12345679/000", o_sum, o_cout, o_ovf, o_id);
    end
    last_g = 0;
  endtask

  task automatic test_backpressure();
    int exp_g;
    logic [W-1:0] es; logic ec, eo;
    set_req(0, W'($urandom), W'($urandom), 1'b0, 1'b1);
    set_req(1, W'($urandom), W'($urandom), 1'b1, 1'b0);
    exp_g = 1 - last_g;
    ref_op(ta[exp_g], tb_b[exp_g], ts[exp_g], tc[exp_g], es, ec, eo);
    drive_op(3);
    total++;
    if (o_to || o_unstable) begin bad++; $display("FAIL bp_stable got=%0b exp=0", o_unstable); end
    total++;
    if (o_done_rdy_bad || o_run_rdy_bad) begin bad++; $display("FAIL bp_req_ready got=1 exp=0"); end
    total++;
    if (o_vafter !== 1'b0) begin bad++; $display("FAIL bp_handoff got=%b exp=0", o_vafter); end
    total++;
    if ({o_sum, o_cout, o_ovf, o_id} !== {es, ec, eo, 1'(exp_g)}) begin
      bad++; $display("FAIL bp_result got=%h exp=%h", o_sum, es);
    end
    last_g = o_g;
    exp_g = 1 - exp_g;
    ref_op(ta[exp_g], tb_b[exp_g], ts[exp_g], tc[exp_g], es, ec, eo);
    drive_op(0);
    total++;
    if (o_to || {o_sum, o_cout, o_ovf, o_id} !== {es, ec, eo, 1'(exp_g)}) begin
      bad++; $display("FAIL bp_pending got=%h/%b exp=%h/%0d", o_sum, o_id, es, exp_g);
    end
    last_g = o_g;
    req_valid = 2'b00;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] es; logic ec, eo;
    set_req(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL mr_accept got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    set_req(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    set_req(1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, add_a, add_b, add_cin} !== 18'd0) begin
      bad++; $display("FAIL mr_quiet got=%h exp=0", {rsp_valid, add_a, add_b, add_cin});
    end
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL mr_rst_ready got=%b exp=00", req_ready); end
    rst = 1'b0;
    last_g = 1;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL mr_rr_reset got=%b exp=01", req_ready); end
    ref_op(ta[0], tb_b[0], ts[0], tc[0], es, ec, eo);
    drive_op(0);
    total++;
    if (o_to || {o_sum, o_cout, o_ovf, o_id} !== {es, ec, eo, 1'b0}) begin
      bad++; $display("FAIL mr_after got=%h/%b exp=%h/0", o_sum, o_id, es);
    end
    last_g = 0;
    ref_op(ta[1], tb_b[1], ts[1], tc[1], es, ec, eo);
    drive_op(0);
    total++;
    if (o_to || {o_sum, o_cout, o_ovf, o_id} !== {es, ec, eo, 1'b1}) begin
      bad++; $display("FAIL mr_second got=%h/%b exp=%h/1", o_sum, o_id, es);
    end
    last_g = 1;
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    int exp_g, hold;
    logic [W-1:0] es, eb; logic ec, eo;
    for (int i = 0; i < 24; i++) begin
      for (int r = 0; r < 2; r++)
        if (!req_valid[r] && ($urandom % 2 == 1))
          set_req(r, pick(), pick(), 1'($urandom), 1'($urandom));
      if (req_valid == 2'b00) set_req(i % 2, pick(), pick(), 1'($urandom), 1'($urandom));
      exp_g = (req_valid == 2'b11) ? 1 - last_g : (req_valid[1] ? 1 : 0);
      ref_op(ta[exp_g], tb_b[exp_g], ts[exp_g], tc[exp_g], es, ec, eo);
      eb = ts[exp_g] ? ~tb_b[exp_g] : tb_b[exp_g];
      hold = $urandom_range(0, 2);
      drive_op(hold);
      total++;
      if (o_to) begin bad++; $display("FAIL rnd_timeout got=1 exp=0"); return; end
      total++;
      if (o_g != exp_g || o_lat != NB + 1) begin
        bad++; $display("FAIL rnd_grant got=%0d/%0d exp=%0d/%0d", o_g, o_lat, exp_g, NB + 1);
      end
      total++;
      if (o_aw !== ta[exp_g] || o_bw !== eb) begin
        bad++; $display("FAIL rnd_slice got=%h/%h exp=%h/%h", o_aw, o_bw, ta[exp_g], eb);
      end
      total++;
      if ({o_sum, o_cout, o_ovf, o_id} !== {es, ec, eo, 1'(exp_g)} || o_unstable) begin
        bad++; $display("FAIL rnd_result got=%h/%b%b%b exp=%h/%b%b%0d", o_sum, o_cout, o_ovf, o_id, es, ec, eo, exp_g);
      end
      last_g = o_g;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_a = '0; req_b = '0; req_sub = 2'b00; req_cin = 2'b00;
    rsp_ready = 1'b0;
    test_reset();
    test_alternate();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
